// File: rtl/can_sim_pkg.sv
// rtl/can_sim_pkg.sv - shared fault-mode encodings, injector state type and clog2 helper
package can_sim_pkg;

  localparam logic [1:0] FM_NONE = 2'b00;
  localparam logic [1:0] FM_DOM  = 2'b01;
  localparam logic [1:0] FM_REC  = 2'b10;
  localparam logic [1:0] FM_INV  = 2'b11;

  typedef logic [0:0] flt_state_t;
  localparam flt_state_t F_IDLE = 1'b0;
  localparam flt_state_t F_ACT  = 1'b1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/can_dly_line.sv
// rtl/can_dly_line.sv - per-node TX shift-register delay line with saturating tap
module can_dly_line
  import can_sim_pkg::*;
#(
  parameter int DLY_MAX = 8,
  parameter int DW      = clog2(DLY_MAX + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          tx_i,
  input  logic [DW-1:0] tap_i,
  output logic          tx_dly_o
);

  logic [DLY_MAX-1:0] sr_q, sr_d;
  logic [DW-1:0]      tap_sat;

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = tx_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sr_q <= '1;
    else       sr_q <= sr_d;
  end

  // Tap 0 bypasses the register chain; tap k selects the bit delayed k cycles.
  always_comb begin
    tap_sat  = (tap_i > DW'(DLY_MAX)) ? DW'(DLY_MAX) : tap_i;
    tx_dly_o = tx_i;
    for (int k = 0; k < DLY_MAX; k++) begin
      if (int'(tap_sat) == k + 1) tx_dly_o = sr_q[k];
    end
  end

endmodule

// File: rtl/can_bus_sim.sv
// rtl/can_bus_sim.sv - wired-AND CAN bus model with per-node delay, fault injector and bus monitors
module can_bus_sim
  import can_sim_pkg::*;
#(
  parameter int N_NODES  = 4,
  parameter int DLY_MAX  = 8,
  parameter int IDLE_CYC = 550,
  parameter int DOM_TO   = 1000,
  localparam int DW      = clog2(DLY_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_NODES-1:0]    node_tx,
  input  logic [N_NODES*DW-1:0] node_dly,
  output logic [N_NODES-1:0]    node_rx,
  input  logic                  flt_valid,
  output logic                  flt_ready,
  input  logic [3:0]            flt_node,
  input  logic [1:0]            flt_mode,
  input  logic [15:0]           flt_len,
  output logic                  bus_idle,
  output logic                  dom_timeout,
  input  logic                  clr,
  output logic [15:0]           edge_cnt
);

  localparam int IW = clog2(IDLE_CYC + 1);
  localparam int TW = clog2(DOM_TO + 1);

  logic [N_NODES-1:0] tx_dly;
  logic               bus;

  for (genvar g = 0; g < N_NODES; g++) begin : g_dly
    can_dly_line #(.DLY_MAX(DLY_MAX)) u_dly (
      .clk      (clk),
      .rstn     (rstn),
      .tx_i     (node_tx[g]),
      .tap_i    (node_dly[g*DW +: DW]),
      .tx_dly_o (tx_dly[g])
    );
  end

  assign bus = &tx_dly;

  logic [N_NODES-1:0] rx_q;
  flt_state_t         state_q, state_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [3:0]         fnode_q, fnode_d;
  logic [1:0]         fmode_q, fmode_d;
  logic [IW-1:0]      rec_q, rec_d;
  logic [TW-1:0]      dom_q, dom_d;
  logic               to_q, to_d;
  logic               prev_q;
  logic [15:0]        edge_q, edge_d;

  // A zero-length request is accepted but never leaves F_IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fnode_d = fnode_q;
    fmode_d = fmode_q;
    if (state_q == F_IDLE) begin
      if (flt_valid && flt_len != 16'd0) begin
        state_d = F_ACT;
        cnt_d   = flt_len;
        fnode_d = flt_node;
        fmode_d = flt_mode;
      end
    end else begin
      cnt_d = cnt_q - 16'd1;
      if (cnt_q == 16'd1) state_d = F_IDLE;
    end
  end

  always_comb begin
    rec_d  = bus ? ((rec_q == IW'(IDLE_CYC)) ? rec_q : rec_q + IW'(1)) : '0;
    dom_d  = bus ? '0 : ((dom_q == TW'(DOM_TO)) ? dom_q : dom_q + TW'(1));
    to_d   = (dom_d == TW'(DOM_TO)) | (to_q & ~clr);
    edge_d = (!bus && prev_q) ? edge_q + 16'd1 : edge_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_q    <= '1;
      state_q <= F_IDLE;
      cnt_q   <= '0;
      fnode_q <= '0;
      fmode_q <= FM_NONE;
      rec_q   <= '0;
      dom_q   <= '0;
      to_q    <= 1'b0;
      prev_q  <= 1'b1;
      edge_q  <= '0;
    end else begin
      rx_q    <= {N_NODES{bus}};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fnode_q <= fnode_d;
      fmode_q <= fmode_d;
      rec_q   <= rec_d;
      dom_q   <= dom_d;
      to_q    <= to_d;
      prev_q  <= bus;
      edge_q  <= edge_d;
    end
  end

  // Override only the receive view of the targeted node; out-of-range targets match nothing.
  always_comb begin
    node_rx = rx_q;
    if (state_q == F_ACT) begin
      for (int i = 0; i < N_NODES; i++) begin
        if (fnode_q == 4'(i)) begin
          case (fmode_q)
            FM_DOM:  node_rx[i] = 1'b0;
            FM_REC:  node_rx[i] = 1'b1;
            FM_INV:  node_rx[i] = ~rx_q[i];
            default: node_rx[i] = rx_q[i];
          endcase
        end
      end
    end
  end

  assign flt_ready   = (state_q == F_IDLE);
  assign bus_idle    = (rec_q == IW'(IDLE_CYC));
  assign dom_timeout = to_q;
  assign edge_cnt    = edge_q;

endmodule

// File: tb/tb_can_bus_sim.sv
// tb/tb_can_bus_sim.sv - directed bench for can_bus_sim with a cycle-level reference model
module tb_can_bus_sim;

  localparam int N    = 4;
  localparam int DM   = 8;
  localparam int IDLE = 550;
  localparam int DTO  = 1000;
  localparam int DW   = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  node_tx;
  logic [N*DW-1:0] node_dly;
  logic [N-1:0]  node_rx;
  logic          flt_valid, flt_ready;
  logic [3:0]    flt_node;
  logic [1:0]    flt_mode;
  logic [15:0]   flt_len;
  logic          bus_idle, dom_timeout, clr;
  logic [15:0]   edge_cnt;

  always #5 clk = ~clk;

  can_bus_sim #(.N_NODES(N), .DLY_MAX(DM), .IDLE_CYC(IDLE), .DOM_TO(DTO)) dut (
    .clk(clk), .rstn(rstn), .node_tx(node_tx), .node_dly(node_dly), .node_rx(node_rx),
    .flt_valid(flt_valid), .flt_ready(flt_ready), .flt_node(flt_node), .flt_mode(flt_mode),
    .flt_len(flt_len), .bus_idle(bus_idle), .dom_timeout(dom_timeout), .clr(clr),
    .edge_cnt(edge_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: history of past TX vectors, run lengths and a remaining-fault counter.
  logic [N-1:0] hist [1:DM];
  logic         m_base, m_prev, m_to, m_b;
  int           m_rec, m_dom, m_left, m_fnode;
  logic [1:0]   m_fmode;
  logic [15:0]  m_edge;

  function automatic logic model_bus();
    logic b;
    int   d;
    b = 1'b1;
    for (int j = 0; j < N; j++) begin
      d = int'(node_dly[j*DW +: DW]);
      if (d > DM) d = DM;
      if (d == 0) b = b & node_tx[j];
      else        b = b & hist[d][j];
    end
    return b;
  endfunction

  function automatic logic [N-1:0] exp_rx();
    logic [N-1:0] r;
    r = {N{m_base}};
    if (m_left > 0 && m_fnode < N) begin
      case (m_fmode)
        2'b01:   r[m_fnode] = 1'b0;
        2'b10:   r[m_fnode] = 1'b1;
        2'b11:   r[m_fnode] = ~r[m_fnode];
        default: ;
      endcase
    end
    return r;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 1; k <= DM; k++) hist[k] = '1;
      m_base = 1'b1; m_prev = 1'b1; m_to = 1'b0;
      m_rec = 0; m_dom = 0; m_left = 0; m_fnode = 0; m_fmode = 2'b00;
      m_edge = 16'd0;
    end else begin
      m_b    = model_bus();
      m_base = m_b;
      m_rec  = m_b ? ((m_rec < IDLE) ? m_rec + 1 : IDLE) : 0;
      m_dom  = m_b ? 0 : ((m_dom < DTO) ? m_dom + 1 : DTO);
      if (m_dom == DTO) m_to = 1'b1;
      else if (clr)     m_to = 1'b0;
      if (!m_b && m_prev) m_edge = m_edge + 16'd1;
      m_prev = m_b;
      if (m_left > 0) m_left = m_left - 1;
      else if (flt_valid && flt_len != 16'd0) begin
        m_left  = int'(flt_len);
        m_fnode = int'(flt_node);
        m_fmode = flt_mode;
      end
      for (int k = DM; k > 1; k--) hist[k] = hist[k-1];
      hist[1] = node_tx;
    end
  end

  always @(negedge clk) begin
    chk("node_rx", 32'(node_rx), 32'(exp_rx()));
    chk("flt_ready", 32'(flt_ready), 32'(m_left == 0));
    chk("bus_idle", 32'(bus_idle), 32'(m_rec == IDLE));
    chk("dom_timeout", 32'(dom_timeout), 32'(m_to));
    chk("edge_cnt", 32'(edge_cnt), 32'(m_edge));
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rstn = 1'b0;
    node_tx = '1;
    node_dly = {4'd15, 4'd8, 4'd3, 4'd0};
    flt_valid = 1'b0; flt_node = 4'd0; flt_mode = 2'b00; flt_len = 16'd0;
    clr = 1'b0;
    step(3);
    rstn = 1'b1;
    step(2);
    chk("post_reset_rx", 32'(node_rx), 32'hF);
    chk("post_reset_ready", 32'(flt_ready), 32'd1);

    // node 1 (tap 3) one-cycle dominant pulse
    node_tx[1] = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) node_tx[1] = 1'b1;
      chk("dly3_rx", 32'(node_rx), (c == 4) ? 32'h0 : 32'hF);
    end
    chk("dly3_edges", 32'(edge_cnt), 32'd1);

    // node 3 tap 15 saturates to 8
    node_tx[3] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) node_tx[3] = 1'b1;
      chk("dly_sat_rx", 32'(node_rx), (c == 9) ? 32'h0 : 32'hF);
    end

    // arbitration and idle detection
    node_tx[0] = 1'b0;
    step();
    chk("arb_rx", 32'(node_rx), 32'h0);
    node_tx[0] = 1'b1;
    step(549);
    chk("idle_549", 32'(bus_idle), 32'd0);
    step();
    chk("idle_550", 32'(bus_idle), 32'd1);

    // force-dominant fault on node 2, second request dropped
    chk("flt_ready_pre", 32'(flt_ready), 32'd1);
    flt_valid = 1'b1; flt_node = 4'd2; flt_mode = 2'b01; flt_len = 16'd5;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 1) flt_valid = 1'b0;
      chk("flt_rx", 32'(node_rx), (c <= 5) ? 32'hB : 32'hF);
      chk("flt_ready", 32'(flt_ready), (c <= 5) ? 32'd0 : 32'd1);
      if (c == 2) begin
        flt_valid = 1'b1; flt_node = 4'd0; flt_mode = 2'b01; flt_len = 16'd3;
      end
      if (c == 3) flt_valid = 1'b0;
    end

    // stuck-dominant timeout with clr interplay
    node_dly = '0;
    node_tx[3] = 1'b0;
    step(999);
    chk("to_999", 32'(dom_timeout), 32'd0);
    step();
    chk("to_1000", 32'(dom_timeout), 32'd1);
    clr = 1'b1;
    step();
    chk("to_clr_dom", 32'(dom_timeout), 32'd1);
    node_tx[3] = 1'b1;
    step();
    chk("to_clr_rel", 32'(dom_timeout), 32'd0);
    clr = 1'b0;

    // force recessive on a dominant node, then out-of-range target
    node_tx[0] = 1'b0;
    flt_valid = 1'b1; flt_node = 4'd0; flt_mode = 2'b10; flt_len = 16'd3;
    step();
    flt_valid = 1'b0;
    chk("rec_rx", 32'(node_rx), 32'h1);
    step(3);
    node_tx[0] = 1'b1;
    flt_valid = 1'b1; flt_node = 4'd9; flt_mode = 2'b01; flt_len = 16'd2;
    step();
    flt_valid = 1'b0;
    chk("oor_ready1", 32'(flt_ready), 32'd0);
    step();
    chk("oor_rx", 32'(node_rx), 32'hF);
    step();
    chk("oor_ready3", 32'(flt_ready), 32'd1);

    // reset in the middle of an invert fault
    flt_valid = 1'b1; flt_node = 4'd1; flt_mode = 2'b11; flt_len = 16'd100;
    step();
    flt_valid = 1'b0;
    step();
    chk("inv_rx", 32'(node_rx), 32'hD);
    rstn = 1'b0;
    #1;
    chk("rst_rx", 32'(node_rx), 32'hF);
    chk("rst_ready", 32'(flt_ready), 32'd1);
    chk("rst_idle", 32'(bus_idle), 32'd0);
    chk("rst_to", 32'(dom_timeout), 32'd0);
    chk("rst_edges", 32'(edge_cnt), 32'd0);
    step(2);
    rstn = 1'b1;
    step();
    chk("rel_rx", 32'(node_rx), 32'hF);
    chk("rel_ready", 32'(flt_ready), 32'd1);

    // 65536 falling edges wrap the counter
    for (int i = 0; i < 65536; i++) begin
      node_tx[0] = 1'b0;
      step();
      if (i == 65534) chk("edge_ffff", 32'(edge_cnt), 32'hFFFF);
      node_tx[0] = 1'b1;
      step();
    end
    chk("edge_wrap", 32'(edge_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_bus_sim.md
CAN_BUS_SIM -- requirements
Module: can_bus_sim

Interface
REQ-001 SHALL have parameter N_NODES, default 4: number of attached CAN nodes (2..16).
REQ-002 SHALL have parameter DLY_MAX, default 8: maximum per-node propagation delay in clk cycles (1..64).
REQ-003 SHALL have parameter IDLE_CYC, default 550: consecutive recessive cycles before the bus is reported idle.
REQ-004 SHALL have parameter DOM_TO, default 1000: consecutive dominant cycles that flag a stuck-dominant bus.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-006 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port node_tx, input, N_NODES bits: per-node transmit; 1 = recessive, 0 = dominant.
REQ-008 SHALL have port node_dly, input, N_NODES*DW bits, DW = clog2(DLY_MAX+1): per-node TX delay; node i uses slice [i*DW +: DW].
REQ-009 SHALL have port node_rx, output, N_NODES bits: per-node receive level; 1 = recessive.
REQ-010 SHALL have port flt_valid, input, 1 bit: fault request valid.
REQ-011 SHALL have port flt_ready, output, 1 bit: injector can accept a request.
REQ-012 SHALL have port flt_node, input, 4 bits: target node index.
REQ-013 SHALL have port flt_mode, input, 2 bits: 00 none, 01 force dominant, 10 force recessive, 11 invert.
REQ-014 SHALL have port flt_len, input, 16 bits: fault duration in cycles.
REQ-015 SHALL have port bus_idle, output, 1 bit: bus idle indication.
REQ-016 SHALL have port dom_timeout, output, 1 bit: sticky stuck-dominant flag.
REQ-017 SHALL have port clr, input, 1 bit: clears dom_timeout.
REQ-018 SHALL have port edge_cnt, output, 16 bits: count of bus recessive-to-dominant edges.

Function
REQ-019 Each node_tx[i] SHALL pass through a shift-register delay line; tap = node_dly slice.
- Tap 0 is a combinational pass-through.
- A tap value above DLY_MAX SHALL saturate to DLY_MAX.
REQ-020 bus = AND of all delayed TX bits (wired-AND: dominant wins).
REQ-021 node_rx[i] SHALL be registered from bus, so latency from node_tx[j] to node_rx[i] = node_dly[j] + 1 cycles.
REQ-022 Injector FSM SHALL have two states:
- F_IDLE: flt_ready = 1. On flt_valid & flt_ready, load counter with flt_len, latch flt_node and flt_mode, go to F_ACT. If flt_len = 0, stay in F_IDLE.
- F_ACT: flt_ready = 0. Counter decrements each cycle; return to F_IDLE when it reaches 0.
REQ-023 While in F_ACT, node_rx[latched node] SHALL be overridden per mode for exactly flt_len consecutive node_rx cycles, starting the cycle after acceptance. Other nodes and the bus are unaffected.
REQ-024 Mode 00, or flt_node >= N_NODES, SHALL be accepted and consume flt_len cycles with no override.
REQ-025 flt_valid while flt_ready = 0 SHALL be ignored (not queued).
REQ-026 bus_idle SHALL be 1 when the recessive run counter reaches IDLE_CYC; the counter saturates there. Any dominant bus cycle SHALL zero the counter and deassert bus_idle on the next cycle.
REQ-027 dom_timeout SHALL set when the dominant run counter reaches DOM_TO (counter saturates) and stay set until clr. If set and clr occur in the same cycle, set wins.
REQ-028 edge_cnt SHALL increment on each cycle where bus is 0 and the previous cycle's bus was 1, wrapping from 0xFFFF to 0.
REQ-029 A delay change mid-traffic SHALL take effect immediately, with no glitch suppression.

Reset
REQ-030 While rstn = 0, the following SHALL hold:
- Delay lines filled with 1.
- node_rx all 1.
- FSM in F_IDLE, flt_ready = 1.
- bus_idle 0; run counters 0.
- dom_timeout 0; edge_cnt 0.
- Previous-bus register 1.
REQ-031 Reset during F_ACT SHALL abort the fault immediately; no override is visible after release.

Structure
REQ-032 A shared package can_sim_pkg SHALL hold the flt_mode encodings, the FSM state typedef and a clog2 function.
REQ-033 The per-node delay line SHALL be one sub-module, can_dly_line (parameter DLY_MAX), instantiated N_NODES times in a generate loop.

Verification
REQ-034 Bench SHALL cover the following directed scenarios:
- Delay/latency: node_dly = {0,3,8,8}; node 1 pulses tx 0 for 1 cycle -> every node_rx shows 0 exactly 4 cycles later, for 1 cycle; edge_cnt = 1.
- Arbitration: node 0 tx 0 while others 1 -> all node_rx 0. Then all 1 for 550 cycles -> bus_idle asserts on cycle 550, not before.
- Fault: flt_node = 2, mode 01, len 5, accepted -> node_rx[2] = 0 for 5 cycles with bus recessive; flt_ready low for 5 cycles; a second flt_valid during that window is dropped.
- Timeout: node 3 holds tx 0 for 1000 cycles -> dom_timeout sets; clr together with continued dominance keeps it set; clr after release clears it.
- Wrap and reset: 65536 edges -> edge_cnt returns to 0. rstn pulsed mid-F_ACT (mode 11) -> all outputs return to their reset values at once.
